universal_register: RTL and testbench

Parametrised successor to the single-bit D flip-flop. It is a WIDTH-bit edge-triggered register with a 3-bit mode select covering hold, load, increment, decrement, shift/rotate and clear. It keeps a registered carry/borrow flag, a combinational zero flag, and a tri-state bus driver. It serves as the generic accumulator, B, program-counter and shift register of the SAP datapath, all on the shared bus.

---
 rtl/universal_register_if.sv | 25 ++
 rtl/universal_register.sv | 84 ++++++++
 tb/tb_universal_register.sv | 139 +++++++++++++
 3 files changed

// File: rtl/universal_register_if.sv
// Shared-bus signal bundle for universal_register: control and data in, register
// state and tri-state bus drive out.
interface universal_register_if #(
  parameter int WIDTH = 8
) ();
  logic [2:0]       mode;
  logic [WIDTH-1:0] data;
  logic             serial_in;
  logic             bus_oe;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_not;
  wire  [WIDTH-1:0] bus_out;
  logic             carry;
  logic             zero;

  modport master (
    output mode, data, serial_in, bus_oe,
    input  q, q_not, bus_out, carry, zero
  );

  modport slave (
    input  mode, data, serial_in, bus_oe,
    output q, q_not, bus_out, carry, zero
  );
endinterface

// File: rtl/universal_register.sv
// WIDTH-bit multi-mode register (hold/load/inc/dec/shift/rotate/clear) with carry,
// zero flag and tri-state bus driver. UNIVERSAL_REGISTER_SHIFT_EN enables shift/rotate.
module universal_register #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  universal_register_if.slave  bus
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_INC  = 3'b010;
  localparam logic [2:0] M_DEC  = 3'b011;
  localparam logic [2:0] M_SHL  = 3'b100;
  localparam logic [2:0] M_SHR  = 3'b101;
  localparam logic [2:0] M_ROL  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  logic [WIDTH-1:0] q_r, q_nxt;
  logic             c_r, c_nxt;

  always_comb begin
    q_nxt = q_r;
    c_nxt = c_r;
    case (bus.mode)
      M_HOLD: ;
      M_LOAD: begin
        q_nxt = bus.data;
        c_nxt = 1'b0;
      end
      M_INC: {c_nxt, q_nxt} = {1'b0, q_r} + {{WIDTH{1'b0}}, 1'b1};
      M_DEC: begin
        q_nxt = q_r - {{(WIDTH-1){1'b0}}, 1'b1};
        c_nxt = (q_r == '0);
      end
`ifdef UNIVERSAL_REGISTER_SHIFT_EN
      M_SHL: begin
        q_nxt = {q_r[WIDTH-2:0], bus.serial_in};
        c_nxt = q_r[WIDTH-1];
      end
      M_SHR: begin
        q_nxt = {bus.serial_in, q_r[WIDTH-1:1]};
        c_nxt = q_r[0];
      end
      M_ROL: begin
        q_nxt = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        c_nxt = q_r[WIDTH-1];
      end
`else
      M_SHL, M_SHR, M_ROL: ;
`endif
      M_CLR: begin
        q_nxt = '0;
        c_nxt = 1'b0;
      end
      // Unknown mode bits fall here and keep the current state.
      default: ;
    endcase
  end

`ifndef UNIVERSAL_REGISTER_SHIFT_EN
  logic unused_serial_in;
  assign unused_serial_in = bus.serial_in;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_r <= RESET_VALUE;
      c_r <= 1'b0;
    end else begin
      q_r <= q_nxt;
      c_r <= c_nxt;
    end
  end

  assign bus.q       = q_r;
  assign bus.q_not   = ~q_r;
  assign bus.carry   = c_r;
  assign bus.zero    = (q_r == '0);
  assign bus.bus_out = bus.bus_oe ? q_r : {WIDTH{1'bz}};

endmodule

// File: tb/tb_universal_register.sv
// Vector-table bench for universal_register (WIDTH=8, RESET_VALUE=A5) with an
// expected-value queue; shift expectations follow UNIVERSAL_REGISTER_SHIFT_EN.
module tb_universal_register;
  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'hA5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  universal_register_if #(.WIDTH(W)) bus ();
  universal_register #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic       rst_n;
    logic [2:0] mode;
    logic [7:0] data;
    logic       si;
    logic       oe;
    logic [7:0] q;
    logic       c;
    logic       z;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t v(logic r, logic [2:0] m, logic [7:0] d, logic si, logic oe,
                             logic [7:0] q, logic c, logic z);
    vec_t t;
    t.rst_n = r; t.mode = m; t.data = d; t.si = si; t.oe = oe;
    t.q = q; t.c = c; t.z = z;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    @(negedge clk);
    rst_n         = t.rst_n;
    bus.mode      = t.mode;
    bus.data      = t.data;
    bus.serial_in = t.si;
    bus.bus_oe    = t.oe;
    sb.push_back(t);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL scoreboard: got empty queue, expected entry");
    end else begin
      vec_t e;
      e = sb.pop_front();
      chk("q", bus.q, e.q);
      chk("q_not", bus.q_not, ~e.q);
      chk("carry", {7'd0, bus.carry}, {7'd0, e.c});
      chk("zero", {7'd0, bus.zero}, {7'd0, e.z});
      if (e.oe) chk("bus_out", bus.bus_out, e.q);
    end
  endtask

  initial begin
    rst_n = 1'b0; bus.mode = 3'b000; bus.data = '0; bus.serial_in = 1'b0; bus.bus_oe = 1'b0;

    // reset, LOAD blocked by reset, load zero, hold, bus drive
    vecs.push_back(v(0, 3'b000, 8'h00, 0, 0, 8'hA5, 0, 0));
    vecs.push_back(v(0, 3'b001, 8'h3C, 0, 0, 8'hA5, 0, 0));
    vecs.push_back(v(1, 3'b001, 8'h00, 0, 0, 8'h00, 0, 1));
    vecs.push_back(v(1, 3'b000, 8'h77, 0, 0, 8'h00, 0, 1));
    vecs.push_back(v(1, 3'b000, 8'h77, 0, 0, 8'h00, 0, 1));
    vecs.push_back(v(1, 3'b000, 8'h77, 0, 1, 8'h00, 0, 1));
    // increment wrap
    vecs.push_back(v(1, 3'b001, 8'hFE, 0, 0, 8'hFE, 0, 0));
    vecs.push_back(v(1, 3'b010, 8'h00, 0, 0, 8'hFF, 0, 0));
    vecs.push_back(v(1, 3'b010, 8'h00, 0, 1, 8'h00, 1, 1));
    vecs.push_back(v(1, 3'b010, 8'h00, 0, 0, 8'h01, 0, 0));
    // decrement borrow, then hold keeps carry
    vecs.push_back(v(1, 3'b001, 8'h01, 0, 0, 8'h01, 0, 0));
    vecs.push_back(v(1, 3'b011, 8'h00, 0, 0, 8'h00, 0, 1));
    vecs.push_back(v(1, 3'b011, 8'h00, 0, 0, 8'hFF, 1, 0));
    vecs.push_back(v(1, 3'b000, 8'h00, 1, 1, 8'hFF, 1, 0));
    // shift / rotate
    vecs.push_back(v(1, 3'b001, 8'h81, 0, 0, 8'h81, 0, 0));
`ifdef UNIVERSAL_REGISTER_SHIFT_EN
    vecs.push_back(v(1, 3'b100, 8'h00, 0, 0, 8'h02, 1, 0));
    vecs.push_back(v(1, 3'b101, 8'h00, 1, 0, 8'h81, 0, 0));
    vecs.push_back(v(1, 3'b110, 8'h00, 0, 0, 8'h03, 1, 0));
`else
    vecs.push_back(v(1, 3'b100, 8'h00, 0, 0, 8'h81, 0, 0));
    vecs.push_back(v(1, 3'b101, 8'h00, 1, 0, 8'h81, 0, 0));
    vecs.push_back(v(1, 3'b110, 8'h00, 0, 0, 8'h81, 0, 0));
`endif
    // reset aborts an INC run; next edge acts on RESET_VALUE; then CLR
    vecs.push_back(v(1, 3'b001, 8'hF0, 0, 0, 8'hF0, 0, 0));
    vecs.push_back(v(1, 3'b010, 8'h00, 0, 0, 8'hF1, 0, 0));
    vecs.push_back(v(1, 3'b010, 8'h00, 0, 0, 8'hF2, 0, 0));
    vecs.push_back(v(0, 3'b010, 8'h00, 0, 0, 8'hA5, 0, 0));
    vecs.push_back(v(1, 3'b010, 8'h00, 0, 0, 8'hA6, 0, 0));
    vecs.push_back(v(1, 3'b111, 8'h00, 0, 1, 8'h00, 0, 1));
    vecs.push_back(v(1, 3'b001, 8'h5A, 0, 0, 8'h5A, 0, 0));

    for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);

    // bus_oe acts between edges, with no register effect
    @(negedge clk);
    bus.mode = 3'b000;
    bus.bus_oe = 1'b1;
    #1 chk("bus_out_async_on", bus.bus_out, 8'h5A);
    bus.bus_oe = 1'b0;
    #1;
    tests++;
    if (bus.bus_out === 8'h5A) begin
      fails++;
      $display("FAIL bus_out_release: got %h, expected zz", bus.bus_out);
    end
    @(posedge clk);
    #1 chk("q_after_oe_toggle", bus.q, 8'h5A);

    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_drain: got %0d left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
